// File: rtl/state_dump_sequencer.sv
// state_dump_sequencer
//
// Watches a single-cycle machine while it runs. Each RUN cycle it emits one
// PC trace record. It halts the run on a zero instruction word or when the
// cycle budget runs out. After the halt it freezes the machine and streams
// out the register file and a data-memory window as valid/ready records.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-low reset
//   start                one-cycle pulse that begins a run (from IDLE or DONE)
//   pc, inst             machine byte PC and current instruction word
//   halt_req             stall request to the machine, registered
//   rf_raddr, rf_rdata   register-file read port (data is combinational)
//   mem_raddr, mem_rdata data-memory word read port (data is combinational)
//   out_valid/out_ready  record handshake
//   out_kind, out_data   record type (0=PC, 1=register, 2=memory) and payload
//   done                 dump complete, sticky until start or reset
//   halt_cause           0=zero instruction, 1=timeout
//   overflow             sticky, set when a PC record was dropped
module state_dump_sequencer #(
    parameter int unsigned NUM_REGS       = 32,
    parameter logic [31:0] MEM_BASE       = 32'h4000,
    parameter int unsigned MEM_WORDS      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        halt_req,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [31:0] out_data,
    output logic        done,
    output logic        halt_cause,
    output logic        overflow
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DUMP_REG,
        DUMP_MEM,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] idx;
    logic [31:0] cyc_cnt;
    logic        zero_hit;
    logic        time_hit;
    logic        last_reg;
    logic        last_mem;

    assign zero_hit = (inst == 32'd0);
    assign time_hit = (cyc_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign last_reg = (idx == 32'(NUM_REGS - 1));
    assign last_mem = (idx == 32'(MEM_WORDS - 1));

    // Read addresses follow the dump index directly; the add wraps mod 2^32.
    assign rf_raddr  = idx[4:0];
    assign mem_raddr = MEM_BASE + idx;

    // Payload is a pure select so it tracks the combinational read ports and
    // stays stable while the index is held under backpressure.
    always_comb begin
        out_data = 32'd0;
        unique case (state)
            RUN:      out_data = pc;
            DUMP_REG: out_data = rf_rdata;
            DUMP_MEM: out_data = mem_rdata;
            default:  out_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= 32'd0;
            cyc_cnt    <= 32'd0;
            out_valid  <= 1'b0;
            out_kind   <= 2'd0;
            done       <= 1'b0;
            halt_cause <= 1'b0;
            overflow   <= 1'b0;
            halt_req   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        idx        <= 32'd0;
                        cyc_cnt    <= 32'd0;
                        overflow   <= 1'b0;
                        halt_cause <= 1'b0;
                        done       <= 1'b0;
                        halt_req   <= 1'b0;
                        out_valid  <= 1'b1;
                        out_kind   <= 2'd0;
                    end
                end
                RUN: begin
                    cyc_cnt <= cyc_cnt + 32'd1;
                    // The PC stream cannot stall: an unaccepted record is lost.
                    if (!out_ready) begin
                        overflow <= 1'b1;
                    end
                    if (zero_hit || time_hit) begin
                        state      <= DUMP_REG;
                        halt_cause <= !zero_hit;
                        halt_req   <= 1'b1;
                        idx        <= 32'd0;
                        out_kind   <= 2'd1;
                    end
                end
                DUMP_REG: begin
                    if (out_ready) begin
                        if (last_reg) begin
                            idx      <= 32'd0;
                            state    <= DUMP_MEM;
                            out_kind <= 2'd2;
                        end else begin
                            idx <= idx + 32'd1;
                        end
                    end
                end
                DUMP_MEM: begin
                    if (out_ready) begin
                        if (last_mem) begin
                            idx       <= 32'd0;
                            state     <= DONE;
                            out_valid <= 1'b0;
                            out_kind  <= 2'd0;
                            done      <= 1'b1;
                        end else begin
                            idx <= idx + 32'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_sequencer.sv
module tb_state_dump_sequencer;

    localparam int          NREGS   = 32;
    localparam logic [31:0] MBASE   = 32'h4000;
    localparam int          MWORDS  = 4;
    localparam int          TIMEOUT = 64;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt_req;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [31:0] out_data;
    logic        done;
    logic        halt_cause;
    logic        overflow;

    state_dump_sequencer #(
        .NUM_REGS       (NREGS),
        .MEM_BASE       (MBASE),
        .MEM_WORDS      (MWORDS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .inst       (inst),
        .halt_req   (halt_req),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_kind   (out_kind),
        .out_data   (out_data),
        .done       (done),
        .halt_cause (halt_cause),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Machine state models: register file and the dumped memory window.
    logic [31:0] rf [NREGS];
    logic [31:0] mem [MWORDS];
    logic [31:0] moff;

    assign rf_rdata = rf[rf_raddr];
    assign moff     = mem_raddr - MBASE;
    assign mem_rdata = (moff < MWORDS) ? mem[moff[1:0]] : (32'hBAD0_0000 ^ mem_raddr);

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] data;
    } rec_t;

    rec_t exp_q[$];
    int   vectors;
    int   miscompares;
    logic mon_off;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted record.
    logic        hold_chk;
    logic [1:0]  hold_kind;
    logic [31:0] hold_data;
    rec_t        e;

    initial hold_chk = 1'b0;

    always @(negedge clk) begin
        if (!reset || mon_off) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                vectors++;
                if (!out_valid || out_kind !== hold_kind || out_data !== hold_data) begin
                    miscompares++;
                    $display("FAIL hold: got v=%0b k=%0d d=0x%08h expected v=1 k=%0d d=0x%08h",
                             out_valid, out_kind, out_data, hold_kind, hold_data);
                end
            end
            hold_chk = 1'b0;
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL record: got unexpected k=%0d d=0x%08h, expected none",
                             out_kind, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_kind !== e.kind || out_data !== e.data) begin
                        miscompares++;
                        $display("FAIL record: got k=%0d d=0x%08h expected k=%0d d=0x%08h",
                                 out_kind, out_data, e.kind, e.data);
                    end
                end
            end
            if (out_valid && out_kind != 2'd0) begin
                vectors++;
                if (halt_req !== 1'b1) begin
                    miscompares++;
                    $display("FAIL halt_req_dump: got %0b expected 1", halt_req);
                end
            end
            if (out_valid && !out_ready && out_kind != 2'd0) begin
                hold_chk  = 1'b1;
                hold_kind = out_kind;
                hold_data = out_data;
            end
        end
    end

    // One complete run. halt_at: RUN cycle index with inst==0 (>= TIMEOUT means never).
    // rmode: 0 ready always, 1 random, 2 ready low on RUN cycles 1..2.
    // dmode: 0 ready always, 1 pattern 1-0-0-1, 2 random.
    task automatic do_run(input int halt_at, input int rmode, input int dmode,
                          input logic [31:0] pc_base);
        int   last;
        logic exp_ovf;
        logic exp_cause;
        logic rdy;
        bit   finished;
        for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
        for (int i = 0; i < MWORDS; i++) mem[i] = $urandom;
        rf[11] = 32'd123;
        rf[15] = 32'd100000;
        last      = (halt_at < TIMEOUT) ? halt_at : TIMEOUT - 1;
        exp_cause = (halt_at < TIMEOUT) ? 1'b0 : 1'b1;
        exp_ovf   = 1'b0;

        @(posedge clk);
        #1 start = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                start = 1'b0;
                check("run_done_clr", {31'd0, done}, 32'd0);
                check("run_halt_clr", {31'd0, halt_req}, 32'd0);
                check("run_ovf_clr", {31'd0, overflow}, 32'd0);
                check("run_valid", {31'd0, out_valid}, 32'd1);
            end else begin
                start = ($urandom_range(0, 7) == 0);
            end
            pc   = pc_base + 32'(4 * k);
            inst = (k == halt_at) ? 32'd0 : ($urandom | 32'd1);
            case (rmode)
                1:       rdy = ($urandom_range(0, 3) != 0);
                2:       rdy = !(k == 1 || k == 2);
                default: rdy = 1'b1;
            endcase
            out_ready = rdy;
            if (!rdy) exp_ovf = 1'b1;
            else exp_q.push_back('{kind: 2'd0, data: pc});
        end
        for (int i = 0; i < NREGS; i++) exp_q.push_back('{kind: 2'd1, data: rf[i]});
        for (int i = 0; i < MWORDS; i++) exp_q.push_back('{kind: 2'd2, data: mem[i]});

        finished = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                finished = 1'b1;
                break;
            end
            inst = $urandom;
            case (dmode)
                1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
                2:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            start = ($urandom_range(0, 9) == 0);
        end
        start = 1'b0;
        check("done_reached", {31'd0, finished}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        check("halt_cause", {31'd0, halt_cause}, {31'd0, exp_cause});
        check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        check("halt_req_done", {31'd0, halt_req}, 32'd1);
        check("valid_done", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
    endtask

    task automatic reset_mid_dump();
        bit hit;
        for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        out_ready = 1'b1;
        pc   = 32'h0040_0000;
        inst = 32'd0;
        exp_q.push_back('{kind: 2'd0, data: pc});
        for (int i = 0; i < NREGS; i++) exp_q.push_back('{kind: 2'd1, data: rf[i]});
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && out_kind == 2'd1 && rf_raddr == 5'd10) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_r10", {31'd0, hit}, 32'd1);
        #2;
        mon_off = 1'b1;
        reset   = 1'b0;
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_halt", {31'd0, halt_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_raddr", {27'd0, rf_raddr}, 32'd0);
        check("rst_maddr", mem_raddr, MBASE);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset   = 1'b1;
        mon_off = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_off     = 1'b0;
        reset       = 1'b0;
        start       = 1'b0;
        pc          = 32'd0;
        inst        = 32'd1;
        out_ready   = 1'b1;
        for (int i = 0; i < NREGS; i++) rf[i] = 32'd0;
        for (int i = 0; i < MWORDS; i++) mem[i] = 32'd0;
        #12;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_halt", {31'd0, halt_req}, 32'd0);
        check("reset_kind", {30'd0, out_kind}, 32'd0);
        check("reset_maddr", mem_raddr, MBASE);
        @(negedge clk);
        reset = 1'b1;

        do_run(3, 0, 0, 32'h0040_0000);          // zero-instruction halt
        do_run(1000, 0, 0, 32'h0040_0000);       // timeout
        do_run(5, 0, 1, 32'h0040_0000);          // dump backpressure
        do_run(5, 2, 0, 32'h0040_0000);          // PC drop
        do_run(TIMEOUT - 1, 0, 0, 32'h1000_0000); // zero inst and timeout together
        do_run(0, 1, 2, 32'hFFFF_FFF0);          // halt on first cycle
        reset_mid_dump();
        do_run(7, 0, 0, 32'h0040_0000);          // clean run after reset
        for (int r = 0; r < 25; r++) begin
            do_run($urandom_range(0, 80), 1, 2, $urandom & 32'hFFFF_FFFC);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/state_dump_sequencer.md
Name: state_dump_sequencer

Overview:
Sits directly downstream of the single-cycle machine and takes over the end-of-run checking that testbenches currently do by hand. While the machine runs, it streams a per-cycle PC trace. It detects halt, either from a zero instruction word or from a cycle budget running out. After halt it freezes the machine and reads out the whole register file and a data-memory window as a valid/ready record stream for the autograder comparator.

Parameters:
NUM_REGS, 32, number of register-file entries dumped (indices 0..NUM_REGS-1)
MEM_BASE, 32'h4000, first data-memory word index dumped
MEM_WORDS, 4, number of consecutive memory words dumped
TIMEOUT_CYCLES, 64, maximum RUN cycles before a forced halt

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a monitoring run
pc  in  32  machine byte PC ({PC_reg.q, 2'b00})
inst  in  32  machine current instruction word
halt_req  out  1  freezes the machine (stall) when high
rf_raddr  out  5  register-file read index
rf_rdata  in  32  register-file read data, combinational
mem_raddr  out  32  data-memory word index
mem_rdata  in  32  data-memory read data, combinational
out_valid  out  1  record available
out_ready  in  1  consumer accepts record
out_kind  out  2  0=PC, 1=register, 2=memory
out_data  out  32  record payload
done  out  1  dump complete (sticky until start or reset)
halt_cause  out  1  0=zero instruction, 1=timeout
overflow  out  1  sticky: a PC record was dropped

Behaviour:
- States: IDLE, RUN, DUMP_REG, DUMP_MEM, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters cleared.
  - out_valid, done, halt_cause, overflow and halt_req are 0.
  - rf_raddr=0, mem_raddr=MEM_BASE, out_kind=0.
- IDLE:
  - halt_req=0, out_valid=0.
  - start=1 moves to RUN next edge and clears cyc_cnt, overflow and halt_cause.
- RUN:
  - out_valid=1, out_kind=0, out_data=pc every cycle.
  - The PC stream is not stallable: if out_ready=0, that cycle's record is lost and overflow is set sticky.
  - cyc_cnt increments every RUN cycle.
  - Halt is detected on a cycle where inst==0, or where cyc_cnt==TIMEOUT_CYCLES-1. The PC record for the halt cycle is still emitted.
  - Next state after halt is DUMP_REG. halt_cause is set to 0 for zero instruction, 1 for timeout.
  - If both conditions hold in the same cycle, halt_cause=0.
  - Maximum PC records per run is TIMEOUT_CYCLES.
- halt_req:
  - Registered; goes to 1 on the edge that leaves RUN.
  - Stays 1 through DUMP_REG, DUMP_MEM and DONE, so register and memory contents stay stable.
- DUMP_REG:
  - out_valid=1, out_kind=1, rf_raddr=idx, out_data=rf_rdata.
  - idx advances only on out_valid&&out_ready. While out_ready=0, idx, out_kind and out_data hold stable.
  - After the handshake on idx=NUM_REGS-1: idx clears and state moves to DUMP_MEM.
- DUMP_MEM:
  - out_kind=2, mem_raddr=MEM_BASE+idx, out_data=mem_rdata.
  - Same handshake rules as DUMP_REG.
  - After the handshake on idx=MEM_WORDS-1: state moves to DONE.
- DONE:
  - out_valid=0, done=1, halt_req=1.
  - start=1 starts a new run: RUN next edge, with done, halt_req, counters, overflow and halt_cause cleared.
- start is ignored in RUN, DUMP_REG and DUMP_MEM.
- Record count per run is (PC records) + NUM_REGS + MEM_WORDS. No record is duplicated or skipped in the dump phases.
- Address arithmetic: MEM_BASE+idx is a 32-bit add with wrap-around modulo 2^32.
- Reset asserted mid-operation, in any state, aborts immediately to the reset values. Partial dumps are discarded.

Test Plan:
1. Zero-instruction halt: start; pc 0x00400000 stepping +4; inst=0 on the 4th RUN cycle; out_ready=1.
   -> 4 PC records (0x00400000..0x0040000C), then 32 kind=1 records with rf_raddr 0..31, then 4 kind=2 records at mem_raddr 0x4000..0x4003, then done=1, halt_cause=0, overflow=0.
2. Timeout: inst never 0.
   -> exactly 64 PC records, halt_cause=1, then 36 dump records, then done=1.
3. Dump backpressure: preload r[11]=123, r[15]=100000; toggle out_ready 1-0-0-1 during the dump.
   -> out_data holds while ready=0; record for r11 is 0x0000007B and for r15 is 0x000186A0; 36 dump records total; halt_req=1 throughout.
4. PC drop: out_ready=0 for RUN cycles 2-3 of a 6-cycle run.
   -> 4 PC records accepted, overflow=1, dump unaffected.
5. Reset mid-dump: reset=0 asynchronously at register 10 of DUMP_REG.
   -> out_valid, halt_req and done drop to 0 at once, without waiting for a clock edge; after release the block is in IDLE and start begins a clean run.
6. Start handling: start pulsed during RUN.
   -> ignored, cyc_cnt continues. Start pulsed in DONE -> RUN next edge, done=0, halt_req=0, overflow cleared.
